// File: rtl/i2c_pointer_responder.sv
// i2c_pointer_responder: oversampled I2C target that latches a pointer byte on writes
// and streams RD_DATA bytes on reads, with BUSY_IN forcing address NACKs.
module i2c_pointer_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h0C,
  parameter logic [7:0] PTR_RESET = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  input  logic       BUSY_IN,
  input  logic [7:0] RD_DATA,
  output logic [7:0] POINTER,
  output logic       PTR_VALID,
  output logic       RD_REQ,
  output logic       ADDR_HIT,
  output logic [3:0] ST
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_MACK, WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [1:0] scl_s, sda_s;
  logic scl_q, sda_q;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, ptr_n;
  logic oe_n, hit_n, pv_n, rr_n, rw, rw_n, mack, mack_n;
  logic scl, sda, scl_rise, scl_fall, start, stop;
  assign scl = scl_s[1];
  assign sda = sda_s[1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start = scl & scl_q & sda_q & ~sda;
  assign stop = scl & scl_q & ~sda_q & sda;
  assign ST = state;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      SDA_OE <= 1'b0;
      ADDR_HIT <= 1'b0;
      POINTER <= PTR_RESET;
      PTR_VALID <= 1'b0;
      RD_REQ <= 1'b0;
      rw <= 1'b0;
      mack <= 1'b0;
    end else begin
      scl_s <= {scl_s[0], SCL_IN};
      sda_s <= {sda_s[0], SDA_IN};
      scl_q <= scl;
      sda_q <= sda;
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      SDA_OE <= oe_n;
      ADDR_HIT <= hit_n;
      POINTER <= ptr_n;
      PTR_VALID <= pv_n;
      RD_REQ <= rr_n;
      rw <= rw_n;
      mack <= mack_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    oe_n = SDA_OE;
    hit_n = ADDR_HIT;
    ptr_n = POINTER;
    pv_n = 1'b0;
    rr_n = 1'b0;
    rw_n = rw;
    mack_n = mack;
    if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
      hit_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      hit_n = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n = {sh[6:0], sda};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            rw_n = sh[0];
            if (sh[7:1] == DEV_ADDR && !BUSY_IN) begin
              oe_n = 1'b1;
              hit_n = 1'b1;
              rr_n = sh[0];
              state_n = ADDR_ACK;
            end else state_n = WAIT_STOP;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_n = rw ? 4'd1 : 4'd0;
          sh_n = rw ? RD_DATA : sh;
          oe_n = rw & ~RD_DATA[7];
          state_n = rw ? TX : PTR;
        end
        PTR: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n = {sh[6:0], sda};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            oe_n = 1'b1;
            ptr_n = sh;
            pv_n = 1'b1;
            state_n = PTR_ACK;
          end
        end
        PTR_ACK: if (scl_fall) begin
          oe_n = 1'b0;
          state_n = WAIT_STOP;
        end
        // cnt holds the number of bits already placed on the bus
        TX: if (scl_fall) begin
          if (cnt == 4'd8) begin
            oe_n = 1'b0;
            mack_n = 1'b0;
            state_n = TX_MACK;
          end else begin
            oe_n = ~sh[6];
            sh_n = {sh[6:0], 1'b0};
            cnt_n = cnt + 4'd1;
          end
        end
        TX_MACK: begin
          if (scl_rise) begin
            rr_n = ~sda;
            mack_n = ~sda;
            state_n = sda ? WAIT_STOP : TX_MACK;
          end else if (scl_fall && mack) begin
            sh_n = RD_DATA;
            oe_n = ~RD_DATA[7];
            cnt_n = 4'd1;
            state_n = TX;
          end
        end
        WAIT_STOP: oe_n = 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_pointer_responder.sv
// tb_i2c_pointer_responder: directed I2C master transactions against the responder.
module tb_i2c_pointer_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1, sda_m = 1'b1, busy = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic sda_oe, ptr_valid, rd_req, addr_hit;
  logic [7:0] pointer;
  logic [3:0] st;
  logic sda_line;
  logic [7:0] rd_q[$];
  int n_chk = 0, n_fail = 0;
  int pv_cnt = 0, rr_cnt = 0, oe_cnt = 0;
  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_pointer_responder dut (
    .CLK(clk), .RESET_N(rst_n), .SCL_IN(scl), .SDA_IN(sda_line), .SDA_OE(sda_oe),
    .BUSY_IN(busy), .RD_DATA(rd_data), .POINTER(pointer), .PTR_VALID(ptr_valid),
    .RD_REQ(rd_req), .ADDR_HIT(addr_hit), .ST(st)
  );
  always @(negedge clk) begin
    if (ptr_valid) pv_cnt++;
    if (sda_oe) oe_cnt++;
    if (rd_req) begin
      rr_cnt++;
      if (rd_q.size() > 0) rd_data = rd_q.pop_front();
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic q_wait;
    repeat (8) @(negedge clk);
  endtask
  task automatic i2c_start;
    sda_m = 1'b1; q_wait;
    scl = 1'b1; q_wait;
    sda_m = 1'b0; q_wait;
    scl = 1'b0; q_wait;
  endtask
  task automatic i2c_stop;
    sda_m = 1'b0; q_wait;
    scl = 1'b1; q_wait;
    sda_m = 1'b1; q_wait;
  endtask
  task automatic write_bit(input logic b);
    sda_m = b; q_wait;
    scl = 1'b1; q_wait; q_wait;
    scl = 1'b0; q_wait;
  endtask
  task automatic read_bit(output logic b);
    sda_m = 1'b1; q_wait;
    scl = 1'b1; q_wait;
    b = sda_line; q_wait;
    scl = 1'b0; q_wait;
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask
  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(~ack);
  endtask
  initial begin
    logic ack;
    logic [7:0] d;
    int pv0, rr0, oe0;
    repeat (4) @(negedge clk);
    check("rst_oe", sda_oe, 0);
    check("rst_ptr", pointer, 8'h00);
    check("rst_st", st, 0);
    check("rst_hit", addr_hit, 0);
    rst_n = 1'b1;
    q_wait;
    pv0 = pv_cnt;
    i2c_start;
    write_byte(8'h18, ack); check("wr_addr_ack", ack, 1);
    check("wr_hit", addr_hit, 1);
    write_byte(8'h5A, ack); check("wr_ptr_ack", ack, 1);
    i2c_stop; q_wait;
    check("wr_ptr", pointer, 8'h5A);
    check("wr_pv_pulses", pv_cnt - pv0, 1);
    check("wr_st_idle", st, 0);
    check("wr_hit_drop", addr_hit, 0);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i2c_start;
      write_byte(8'h18, ack); check("busy_nack", ack, 0);
      check("busy_st", st, 7);
      i2c_stop; q_wait;
    end
    busy = 1'b0;
    i2c_start;
    write_byte(8'h18, ack); check("poll_ack", ack, 1);
    write_byte(8'h33, ack); check("poll_ptr_ack", ack, 1);
    i2c_stop; q_wait;
    check("poll_ptr", pointer, 8'h33);
    oe0 = oe_cnt;
    i2c_start;
    write_byte(8'h1A, ack); check("mis_nack", ack, 0);
    check("mis_st", st, 7);
    write_byte(8'h77, ack); check("mis_data_nack", ack, 0);
    check("mis_st2", st, 7);
    i2c_stop; q_wait;
    check("mis_st_idle", st, 0);
    check("mis_ptr", pointer, 8'h33);
    check("mis_oe_never", oe_cnt - oe0, 0);
    rd_q.push_back(8'hA5);
    rd_q.push_back(8'h3C);
    rr0 = rr_cnt;
    i2c_start;
    write_byte(8'h19, ack); check("rd_addr_ack", ack, 1);
    read_byte(d, 1'b1); check("rd_byte0", d, 8'hA5);
    read_byte(d, 1'b0); check("rd_byte1", d, 8'h3C);
    check("rd_st_after_nack", st, 7);
    i2c_stop; q_wait;
    check("rd_req_pulses", rr_cnt - rr0, 2);
    check("rd_st_idle", st, 0);
    rd_q.push_back(8'h81);
    i2c_start;
    write_byte(8'h18, ack); check("sr_addr_ack", ack, 1);
    write_byte(8'h10, ack); check("sr_ptr_ack", ack, 1);
    check("sr_hit_before", addr_hit, 1);
    i2c_start;
    check("sr_hit_drop", addr_hit, 0);
    check("sr_st_addr", st, 1);
    write_byte(8'h19, ack); check("sr_rd_ack", ack, 1);
    check("sr_hit_again", addr_hit, 1);
    read_byte(d, 1'b0); check("sr_rd_byte", d, 8'h81);
    i2c_stop; q_wait;
    check("sr_ptr", pointer, 8'h10);
    rd_q.push_back(8'h00);
    i2c_start;
    write_byte(8'h19, ack); check("rm_addr_ack", ack, 1);
    check("rm_oe_driving", sda_oe, 1);
    check("rm_st_tx", st, 5);
    rst_n = 1'b0;
    #1;
    check("rm_oe_async", sda_oe, 0);
    check("rm_ptr", pointer, 8'h00);
    check("rm_st", st, 0);
    scl = 1'b1; sda_m = 1'b1;
    q_wait;
    rst_n = 1'b1;
    q_wait;
    i2c_start;
    write_byte(8'h18, ack); check("rm_wr_addr_ack", ack, 1);
    write_byte(8'h44, ack); check("rm_wr_ptr_ack", ack, 1);
    i2c_stop; q_wait;
    check("rm_wr_ptr", pointer, 8'h44);
    check("rm_wr_st", st, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
